// File: rtl/uart_frame_loader.sv
// UART 8N1 receiver and packet parser feeding sequential RGB565 writes to the frame buffer.
// Build option: define CHECKSUM_EN to require a trailing mod-256 sum byte per packet.
//
// UART FSM
//   state   | meaning
//   U_IDLE  | line idle, waiting for a synchronized falling edge
//   U_START | half-bit wait, then start bit recheck (high means glitch)
//   U_DATA  | sampling 8 data bits, LSB first
//   U_STOP  | sampling stop bit
// Parser FSM
//   state   | meaning
//   P_HUNT  | discarding bytes until 0xA5
//   P_A2..0 | address bytes, MSB first
//   P_L1/L0 | pixel count minus one, MSB first
//   P_DH/DL | pixel high/low byte
//   P_CS    | checksum byte (CHECKSUM_EN only)
module uart_frame_loader #(
  parameter int CLK_FREQ    = 74250000,
  parameter int BAUD        = 115200,
  parameter int ADDR_BITS   = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [15:0]          wr_data,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 pkt_ok,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);
  localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [3:0] P_HUNT = 4'd0;
  localparam logic [3:0] P_A2   = 4'd1;
  localparam logic [3:0] P_A1   = 4'd2;
  localparam logic [3:0] P_A0   = 4'd3;
  localparam logic [3:0] P_L1   = 4'd4;
  localparam logic [3:0] P_L0   = 4'd5;
  localparam logic [3:0] P_DH   = 4'd6;
  localparam logic [3:0] P_DL   = 4'd7;
`ifdef CHECKSUM_EN
  localparam logic [3:0] P_CS   = 4'd8;
  logic [7:0] csum;
`endif

  logic                 rxd_s1, rxd_s2, rxd_prev;
  logic [1:0]           u_state;
  logic [CW-1:0]        bit_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           rx_byte;
  logic                 byte_valid;
  logic                 stop_bad;

  logic [3:0]           p_state;
  logic [15:0]          addr_hi;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           len_hi;
  logic [15:0]          len_cnt;
  logic [7:0]           pix_hi;
  logic [TW-1:0]        to_cnt;
  logic                 timeout;

  assign stop_bad = (u_state == U_STOP) && (bit_cnt == '0) && !rxd_s2;
  assign busy     = (p_state != P_HUNT);
  assign timeout  = busy && !byte_valid && (to_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1     <= 1'b1;
      rxd_s2     <= 1'b1;
      rxd_prev   <= 1'b1;
      u_state    <= U_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      rxd_s1     <= rxd;
      rxd_s2     <= rxd_s1;
      rxd_prev   <= rxd_s2;
      byte_valid <= 1'b0;
      case (u_state)
        U_IDLE: begin
          if (rxd_prev && !rxd_s2) begin
            u_state <= U_START;
            bit_cnt <= HALF_LD;
          end
        end
        U_START: begin
          if (bit_cnt == '0) begin
            if (!rxd_s2) begin
              u_state <= U_DATA;
              bit_cnt <= FULL_LD;
              bit_idx <= '0;
            end else begin
              u_state <= U_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        U_DATA: begin
          if (bit_cnt == '0) begin
            rx_byte <= {rxd_s2, rx_byte[7:1]};
            bit_cnt <= FULL_LD;
            if (bit_idx == 3'd7) u_state <= U_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        U_STOP: begin
          if (bit_cnt == '0) begin
            u_state    <= U_IDLE;
            byte_valid <= rxd_s2;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        default: u_state <= U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state   <= P_HUNT;
      addr_hi   <= '0;
      addr      <= '0;
      len_hi    <= '0;
      len_cnt   <= '0;
      pix_hi    <= '0;
      to_cnt    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= stop_bad || timeout;
      if (wr_valid && wr_ready) wr_valid <= 1'b0;

      if (byte_valid) to_cnt <= TO_LD;
      else if (busy && to_cnt != '0) to_cnt <= to_cnt - TW'(1);

      if (stop_bad || timeout) begin
        p_state <= P_HUNT;
      end else if (byte_valid) begin
`ifdef CHECKSUM_EN
        if (p_state != P_HUNT && p_state != P_CS) csum <= csum + rx_byte;
`endif
        case (p_state)
          P_HUNT: begin
            if (rx_byte == 8'hA5) p_state <= P_A2;
`ifdef CHECKSUM_EN
            csum <= '0;
`endif
          end
          P_A2: begin addr_hi[15:8] <= rx_byte; p_state <= P_A1; end
          P_A1: begin addr_hi[7:0] <= rx_byte; p_state <= P_A0; end
          P_A0: begin addr <= ADDR_BITS'({addr_hi, rx_byte}); p_state <= P_L1; end
          P_L1: begin len_hi <= rx_byte; p_state <= P_L0; end
          P_L0: begin len_cnt <= {len_hi, rx_byte}; p_state <= P_DH; end
          P_DH: begin pix_hi <= rx_byte; p_state <= P_DL; end
          P_DL: begin
            // A still-pending write wins; the new pixel is dropped but its slot is consumed.
            if (wr_valid && !wr_ready) begin
              overrun <= 1'b1;
            end else begin
              wr_valid <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= {pix_hi, rx_byte};
            end
            addr <= addr + ADDR_BITS'(1);
            if (len_cnt == '0) begin
`ifdef CHECKSUM_EN
              p_state  <= P_CS;
`else
              p_state  <= P_HUNT;
              pkt_done <= 1'b1;
              pkt_ok   <= 1'b1;
`endif
            end else begin
              len_cnt <= len_cnt - 16'd1;
              p_state <= P_DH;
            end
          end
`ifdef CHECKSUM_EN
          P_CS: begin
            p_state  <= P_HUNT;
            pkt_done <= 1'b1;
            pkt_ok   <= (rx_byte == csum);
          end
`endif
          default: p_state <= P_HUNT;
        endcase
      end
    end
  end

endmodule
